// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Multi-cycle subtractor: diff = a - b - bin over WIDTH bits, DIGIT bits per
//   clock, LSB digit first, with the ripple borrow held in a register between
//   cycles. Start/busy/done handshake; reports unsigned borrow out and signed
//   overflow.
//
// Parameters
//   WIDTH  operand/result width (>= 1)
//   DIGIT  bits processed per cycle; must divide WIDTH
//
// Ports
//   clk    rising-edge clock
//   rst    synchronous active-high reset
//   start  request, accepted whenever the unit is not running
//   a, b   minuend / subtrahend, captured with an accepted start
//   bin    borrow into bit 0, captured with an accepted start
//   busy   high while a subtraction is in progress
//   done   one-cycle pulse; diff/bout/ovf valid from this cycle
//   diff   a - b - bin modulo 2^WIDTH, held until the next completion
//   bout   borrow out of the MSB (a < b + bin, unsigned)
//   ovf    signed overflow (borrow into MSB xor borrow out of MSB)

module serial_subtractor #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   generate
      if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
         $error("serial_subtractor: DIGIT must be >= 1 and divide WIDTH");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   state_t           state_nxt;

   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] part;
   logic [WIDTH-1:0] part_nxt;
   logic             br;
   logic [CW-1:0]    cnt;

   logic             accept;
   logic             last;
   logic [DIGIT-1:0] slice_d;
   logic             slice_bout;
   logic             msb_bin;

   // One DIGIT-wide slice of chained full-subtractor cells. The borrow into
   // the slice's top cell is kept: on the final slice it is the borrow into
   // the operand MSB, needed for the overflow flag.
   always_comb begin
      logic bw;
      slice_d = '0;
      msb_bin = 1'b0;
      bw      = br;
      for (int unsigned i = 0; i < DIGIT; i++) begin
         slice_d[i] = a_sh[i] ^ b_sh[i] ^ bw;
         if (i == DIGIT - 1) msb_bin = bw;
         bw = (~a_sh[i] & b_sh[i]) | (~(a_sh[i] ^ b_sh[i]) & bw);
      end
      slice_bout = bw;
   end

   // Slice results enter at the top and move down, so after N slices the
   // first (LSB) slice sits at bit 0.
   always_comb begin
      part_nxt = (part >> DIGIT) | (WIDTH'(slice_d) << (WIDTH - DIGIT));
   end

   always_comb begin
      accept = start && (state != RUN);
      last   = (state == RUN) && (cnt == CW'(N - 1));
      busy   = (state == RUN);
      done   = (state == DONE);
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last)  state_nxt = DONE;
         DONE:    state_nxt = start ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh <= '0;
         b_sh <= '0;
         part <= '0;
         br   <= 1'b0;
         cnt  <= '0;
         diff <= '0;
         bout <= 1'b0;
         ovf  <= 1'b0;
      end else if (accept) begin
         a_sh <= a;
         b_sh <= b;
         part <= '0;
         br   <= bin;
         cnt  <= '0;
      end else if (state == RUN) begin
         a_sh <= a_sh >> DIGIT;
         b_sh <= b_sh >> DIGIT;
         part <= part_nxt;
         br   <= slice_bout;
         cnt  <= cnt + CW'(1);
         if (last) begin
            diff <= part_nxt;
            bout <= slice_bout;
            ovf  <= msb_bin ^ slice_bout;
         end
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
//   Self-checking bench for serial_subtractor. Three instances share clk/rst:
//   WIDTH=1/DIGIT=1, WIDTH=8/DIGIT=1 and WIDTH=16/DIGIT=4. A selector routes
//   stimulus to one instance at a time and muxes its outputs back.

module tb_serial_subtractor;

   logic        clk;
   logic        rst;
   int          sel;
   int          compared;
   int          mismatched;

   logic        start1, a1, b1, bin1, busy1, done1, d1, bout1, ovf1;
   logic        start8, bin8, busy8, done8, bout8, ovf8;
   logic [7:0]  a8, b8, d8;
   logic        start16, bin16, busy16, done16, bout16, ovf16;
   logic [15:0] a16, b16, d16;

   logic        m_busy, m_done, m_bout, m_ovf;
   logic [15:0] m_diff;

   serial_subtractor #(.WIDTH(1), .DIGIT(1)) u1 (
      .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .bin(bin1),
      .busy(busy1), .done(done1), .diff(d1), .bout(bout1), .ovf(ovf1));

   serial_subtractor #(.WIDTH(8), .DIGIT(1)) u8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
      .busy(busy8), .done(done8), .diff(d8), .bout(bout8), .ovf(ovf8));

   serial_subtractor #(.WIDTH(16), .DIGIT(4)) u16 (
      .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .bin(bin16),
      .busy(busy16), .done(done16), .diff(d16), .bout(bout16), .ovf(ovf16));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      m_busy = 1'b0; m_done = 1'b0; m_bout = 1'b0; m_ovf = 1'b0; m_diff = '0;
      case (sel)
         0: begin m_busy = busy1;  m_done = done1;  m_diff = {15'd0, d1}; m_bout = bout1;  m_ovf = ovf1;  end
         1: begin m_busy = busy8;  m_done = done8;  m_diff = {8'd0, d8};  m_bout = bout8;  m_ovf = ovf8;  end
         default: begin m_busy = busy16; m_done = done16; m_diff = d16; m_bout = bout16; m_ovf = ovf16; end
      endcase
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic set_in(input logic [15:0] a, input logic [15:0] b, input logic bi, input logic st);
      case (sel)
         0: begin a1 = a[0]; b1 = b[0]; bin1 = bi; start1 = st; end
         1: begin a8 = a[7:0]; b8 = b[7:0]; bin8 = bi; start8 = st; end
         default: begin a16 = a; b16 = b; bin16 = bi; start16 = st; end
      endcase
   endtask

   // Called #1 after an edge; returns latency in edges after the accepting edge.
   task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic bi,
                        output logic [15:0] d, output logic bo, output logic ov,
                        output int lat, output int bc);
      set_in(a, b, bi, 1'b1);
      @(posedge clk); #1;
      set_in(a, b, bi, 1'b0);
      lat = 0; bc = 0;
      while (!m_done && lat < 100) begin
         if (m_busy) bc++;
         @(posedge clk); #1;
         lat++;
      end
      d = m_diff; bo = m_bout; ov = m_ovf;
   endtask

   // Reference: plain integer arithmetic on unsigned and signed readings.
   task automatic model(input int w, input logic [15:0] a, input logic [15:0] b, input logic bi,
                        output logic [15:0] d, output logic bo, output logic ov);
      longint mask, ua, ub, r, sa, sb, sr, half;
      mask = (64'sd1 <<< w) - 1;
      half = 64'sd1 <<< (w - 1);
      ua = longint'(a) & mask;
      ub = longint'(b) & mask;
      r  = ua - ub - longint'(bi);
      d  = 16'(r & mask);
      bo = (r < 0);
      sa = (ua >= half) ? ua - (64'sd1 <<< w) : ua;
      sb = (ub >= half) ? ub - (64'sd1 <<< w) : ub;
      sr = sa - sb - longint'(bi);
      ov = (sr < -half) || (sr > half - 1);
   endtask

   typedef struct {
      int          s;
      logic [15:0] a;
      logic [15:0] b;
      logic        bi;
      logic [15:0] d;
      logic        bo;
      logic        ov;
   } vec_t;

   vec_t vecs[13];

   initial begin
      logic [15:0] d, md, ra, rb;
      logic        bo, ov, mbo, mov, rbi;
      int          lat, lat2, bc, seen;

      compared = 0; mismatched = 0; sel = 0;
      start1 = 0; a1 = 0; b1 = 0; bin1 = 0;
      start8 = 0; a8 = '0; b8 = '0; bin8 = 0;
      start16 = 0; a16 = '0; b16 = '0; bin16 = 0;

      vecs[0]  = '{0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0};
      vecs[1]  = '{0, 16'h0, 16'h0, 1'b1, 16'h1, 1'b1, 1'b0};
      vecs[2]  = '{0, 16'h0, 16'h1, 1'b0, 16'h1, 1'b1, 1'b1};
      vecs[3]  = '{0, 16'h0, 16'h1, 1'b1, 16'h0, 1'b1, 1'b0};
      vecs[4]  = '{0, 16'h1, 16'h0, 1'b0, 16'h1, 1'b0, 1'b0};
      vecs[5]  = '{0, 16'h1, 16'h0, 1'b1, 16'h0, 1'b0, 1'b1};
      vecs[6]  = '{0, 16'h1, 16'h1, 1'b0, 16'h0, 1'b0, 1'b0};
      vecs[7]  = '{0, 16'h1, 16'h1, 1'b1, 16'h1, 1'b1, 1'b0};
      vecs[8]  = '{1, 16'h05, 16'h03, 1'b0, 16'h02, 1'b0, 1'b0};
      vecs[9]  = '{1, 16'h00, 16'h01, 1'b0, 16'hFF, 1'b1, 1'b0};
      vecs[10] = '{1, 16'h80, 16'h01, 1'b0, 16'h7F, 1'b0, 1'b1};
      vecs[11] = '{1, 16'h7F, 16'hFF, 1'b0, 16'h80, 1'b1, 1'b1};
      vecs[12] = '{1, 16'h00, 16'h00, 1'b1, 16'hFF, 1'b1, 1'b0};

      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      for (int s = 0; s < 3; s++) begin
         sel = s; #0;
         check($sformatf("reset_busy[%0d]", s), 32'(m_busy), 0);
         check($sformatf("reset_done[%0d]", s), 32'(m_done), 0);
         check($sformatf("reset_diff[%0d]", s), 32'(m_diff), 0);
         check($sformatf("reset_bout[%0d]", s), 32'(m_bout), 0);
         check($sformatf("reset_ovf[%0d]", s),  32'(m_ovf), 0);
      end

      // Directed table: WIDTH=1 truth table and WIDTH=8 boundaries.
      foreach (vecs[i]) begin
         sel = vecs[i].s;
         do_op(vecs[i].a, vecs[i].b, vecs[i].bi, d, bo, ov, lat, bc);
         check($sformatf("vec%0d_diff", i), 32'(d),  32'(vecs[i].d));
         check($sformatf("vec%0d_bout", i), 32'(bo), 32'(vecs[i].bo));
         check($sformatf("vec%0d_ovf", i),  32'(ov), 32'(vecs[i].ov));
         check($sformatf("vec%0d_lat", i),  32'(lat), (sel == 0) ? 32'd1 : 32'd8);
         check($sformatf("vec%0d_busy_cycles", i), 32'(bc), (sel == 0) ? 32'd1 : 32'd8);
         @(posedge clk); #1;
         check($sformatf("vec%0d_done_pulse", i), 32'(m_done), 0);
         check($sformatf("vec%0d_hold", i), 32'(m_diff), 32'(vecs[i].d));
      end

      // Start during RUN is ignored; start during DONE is accepted back-to-back.
      sel = 1;
      set_in(16'h35, 16'h12, 1'b0, 1'b1);
      @(posedge clk); #1;
      set_in(16'h35, 16'h12, 1'b0, 1'b0);
      lat = 0;
      while (!m_done && lat < 100) begin
         if (lat == 3) set_in(16'hAA, 16'h55, 1'b1, 1'b1);
         else if (lat == 4) set_in(16'hAA, 16'h55, 1'b1, 1'b0);
         check($sformatf("run_diff_stable@%0d", lat), 32'(m_diff), 32'h0FF);
         @(posedge clk); #1;
         lat++;
      end
      check("ignore_lat", 32'(lat), 8);
      check("ignore_diff", 32'(m_diff), 32'h23);
      check("ignore_bout", 32'(m_bout), 0);
      check("ignore_ovf", 32'(m_ovf), 0);
      set_in(16'h10, 16'h20, 1'b1, 1'b1);
      @(posedge clk); #1;
      set_in(16'h10, 16'h20, 1'b1, 1'b0);
      lat2 = 1;
      while (!m_done && lat2 < 100) begin
         @(posedge clk); #1;
         lat2++;
      end
      check("b2b_gap", 32'(lat2), 9);
      check("b2b_diff", 32'(m_diff), 32'hEF);
      check("b2b_bout", 32'(m_bout), 1);
      check("b2b_ovf", 32'(m_ovf), 0);
      @(posedge clk); #1;

      // Reset in the middle of an operation.
      set_in(16'h05, 16'h03, 1'b0, 1'b1);
      @(posedge clk); #1;
      set_in(16'h05, 16'h03, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rst_busy", 32'(m_busy), 0);
      check("rst_diff", 32'(m_diff), 0);
      check("rst_bout", 32'(m_bout), 0);
      check("rst_ovf",  32'(m_ovf), 0);
      seen = 0;
      for (int c = 0; c < 20; c++) begin
         if (m_done || m_busy) seen++;
         @(posedge clk); #1;
      end
      check("rst_no_done", 32'(seen), 0);
      do_op(16'hC8, 16'h64, 1'b0, d, bo, ov, lat, bc);
      model(8, 16'hC8, 16'h64, 1'b0, md, mbo, mov);
      check("post_rst_diff", 32'(d), 32'(md));
      check("post_rst_bout", 32'(bo), 32'(mbo));
      check("post_rst_ovf", 32'(ov), 32'(mov));
      check("post_rst_lat", 32'(lat), 8);

      // Random WIDTH=16, DIGIT=4 against the arithmetic model.
      sel = 2;
      for (int n = 0; n < 1000; n++) begin
         ra  = 16'($urandom);
         rb  = 16'($urandom);
         rbi = 1'($urandom);
         if ((n % 7) == 0) begin ra = 16'h8000; rb = 16'($urandom_range(0, 2)); end
         if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
         do_op(ra, rb, rbi, d, bo, ov, lat, bc);
         model(16, ra, rb, rbi, md, mbo, mov);
         check($sformatf("rnd%0d_diff", n), 32'(d), 32'(md));
         check($sformatf("rnd%0d_bout", n), 32'(bo), 32'(mbo));
         check($sformatf("rnd%0d_ovf", n), 32'(ov), 32'(mov));
         check($sformatf("rnd%0d_lat", n), 32'(lat), 4);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
